// File: rtl/ex_alu_hazard_pkg.sv
// Shared constants and helpers for the EX-stage ALU / hazard block:
// opcode and funct codes, the 4-bit ALU operation enum, forwarding select
// codes, and the destination / forwarding decode used by the hazard logic.
package ex_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_RA     = 5'd31;

  // Forwarding selects
  localparam logic [1:0] SEL_REG    = 2'b00;
  localparam logic [1:0] SEL_MEM    = 2'b01;
  localparam logic [1:0] SEL_WB     = 2'b10;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRA  = 4'd1,
    ALU_SRL  = 4'd2,
    ALU_MUL  = 4'd3,
    ALU_DIVU = 4'd4,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } alu_op_e;

  // I-type ops that write rt: the 08-0F immediate group plus lw/lbu.
  function automatic logic writes_rt(input logic [5:0] op);
    return (op[5:3] == 3'b001) || (op == OP_LW) || (op == OP_LBU);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LBU);
  endfunction

  // Constant-shift group plus srlv: these take the shifted value from rt.
  function automatic logic is_shift_fn(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) &&
           ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA) || (funct == FN_SRLV));
  endfunction

  // Destination register of an instruction; 0 means "writes nothing".
  function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [5:0] funct,
                                          input logic [4:0] rt, input logic [4:0] rd);
    logic [4:0] d;
    d = REG_ZERO;
    if (op == OP_RTYPE) begin
      if ((funct != FN_JR) && (funct != FN_SYSCALL)) d = rd;
    end else if (writes_rt(op)) begin
      d = rt;
    end else if (op == OP_JAL) begin
      d = REG_RA;
    end
    return d;
  endfunction

  // EX wins over MEM because it holds the younger result. A zero register
  // never matches since a zero destination means "none".
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] ex_dest,
                                         input logic [4:0] mem_dest);
    logic [1:0] s;
    s = SEL_REG;
    if ((ex_dest != REG_ZERO) && (r == ex_dest))        s = SEL_MEM;
    else if ((mem_dest != REG_ZERO) && (r == mem_dest)) s = SEL_WB;
    return s;
  endfunction

endpackage

// File: rtl/ex_alu_hazard_if.sv
// Bundle of the EX-stage ALU / hazard signals (everything except clk, rst
// and the optional stall counter). slave = the ex_alu_hazard block,
// master = whatever drives pipeline fields and consumes results.
interface ex_alu_hazard_if;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt;
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_rt, ex_rd;
  logic [5:0]  mem_op, mem_funct;
  logic [4:0]  mem_rt, mem_rd;
  logic [31:0] ex_rfd1, ex_rfd2, ex_imm;
  logic [1:0]  ex_sel_a, ex_sel_b;
  logic [3:0]  ex_aluop;
  logic [31:0] mem_aluout, wb_data;
  logic [31:0] alu_r, alu_r2;
  logic        alu_of, alu_uof, alu_eq;
  logic        stall;
  logic [1:0]  id_sel_a, id_sel_b, id_rfd1_sel, id_rfd2_sel;

  modport slave (
    input  id_op, id_funct, id_rs, id_rt,
    input  ex_op, ex_funct, ex_rt, ex_rd,
    input  mem_op, mem_funct, mem_rt, mem_rd,
    input  ex_rfd1, ex_rfd2, ex_imm, ex_sel_a, ex_sel_b, ex_aluop,
    input  mem_aluout, wb_data,
    output alu_r, alu_r2, alu_of, alu_uof, alu_eq,
    output stall, id_sel_a, id_sel_b, id_rfd1_sel, id_rfd2_sel
  );

  modport master (
    output id_op, id_funct, id_rs, id_rt,
    output ex_op, ex_funct, ex_rt, ex_rd,
    output mem_op, mem_funct, mem_rt, mem_rd,
    output ex_rfd1, ex_rfd2, ex_imm, ex_sel_a, ex_sel_b, ex_aluop,
    output mem_aluout, wb_data,
    input  alu_r, alu_r2, alu_of, alu_uof, alu_eq,
    input  stall, id_sel_a, id_sel_b, id_rfd1_sel, id_rfd2_sel
  );
endinterface

// File: rtl/ex_alu_hazard_srcb_dec.sv
// Decodes whether operand B comes from the immediate field (immediate ALU
// ops, loads/stores, constant shifts whose shamt rides in the immediate).
// Ports: op, funct in; src_b_imm out. Purely combinational.
module alu_srcb_dec
  import ex_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       src_b_imm
);

  always_comb begin
    src_b_imm = 1'b0;
    if (op == OP_RTYPE) begin
      src_b_imm = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    end else begin
      src_b_imm = writes_rt(op) || (op == OP_SW);
    end
  end

endmodule

// File: rtl/ex_alu_hazard.sv
// EX-stage ALU with operand forwarding muxes, plus ID-stage hazard detect
// (load-use stall, forwarding selects for ID/EX). Optional feature macro:
// STALL_CNT_EN adds a saturating 16-bit stall-cycle counter on port stall_cnt.
// Ports: clk, rst (async active-low), bus (ex_alu_hazard_if.slave),
// [stall_cnt]. All bus outputs are combinational, zero latency.
module ex_alu_hazard
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ex_alu_hazard_if.slave    bus
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // ---------------------------------------------------------------------
  // Hazard detection for the instruction in ID
  // ---------------------------------------------------------------------
  logic       id_src_b_imm, ex_src_b_imm;
  logic [4:0] ex_dest, mem_dest;
  logic [4:0] id_reg_a, id_reg_b;
  logic       stall;

  alu_srcb_dec u_id_dec (.op(bus.id_op), .funct(bus.id_funct), .src_b_imm(id_src_b_imm));
  alu_srcb_dec u_ex_dec (.op(bus.ex_op), .funct(bus.ex_funct), .src_b_imm(ex_src_b_imm));

  assign ex_dest  = dest_reg(bus.ex_op, bus.ex_funct, bus.ex_rt, bus.ex_rd);
  assign mem_dest = dest_reg(bus.mem_op, bus.mem_funct, bus.mem_rt, bus.mem_rd);

  // Shifts put the shifted value (rt) on A; srlv moves rs over to B.
  // Immediate-B instructions have no register B, encoded as $0 so it
  // never matches a destination.
  always_comb begin
    id_reg_a = is_shift_fn(bus.id_op, bus.id_funct) ? bus.id_rt : bus.id_rs;
    id_reg_b = REG_ZERO;
    if ((bus.id_op == OP_RTYPE) && (bus.id_funct == FN_SRLV)) id_reg_b = bus.id_rs;
    else if (!id_src_b_imm)                                   id_reg_b = bus.id_rt;
  end

  // Load data is not available until after MEM, so a consumer directly
  // behind a load must wait a cycle. id_rs/id_rt are compared raw because
  // the controller already substitutes the registers syscall reads.
  assign stall = is_load(bus.ex_op) && (ex_dest != REG_ZERO) &&
                 ((ex_dest == bus.id_rs) || (ex_dest == bus.id_rt));

  // Selects are zeroed during a stall: the ID/EX register receives a bubble.
  always_comb begin
    bus.id_sel_a    = SEL_REG;
    bus.id_sel_b    = SEL_REG;
    bus.id_rfd1_sel = SEL_REG;
    bus.id_rfd2_sel = SEL_REG;
    if (!stall) begin
      bus.id_sel_a    = fwd_sel(id_reg_a,  ex_dest, mem_dest);
      bus.id_sel_b    = fwd_sel(id_reg_b,  ex_dest, mem_dest);
      bus.id_rfd1_sel = fwd_sel(bus.id_rs, ex_dest, mem_dest);
      bus.id_rfd2_sel = fwd_sel(bus.id_rt, ex_dest, mem_dest);
    end
  end

  assign bus.stall = stall;

  // ---------------------------------------------------------------------
  // Operand selection for the instruction in EX
  // ---------------------------------------------------------------------
  logic [31:0] base_a, base_b, x, y;

  always_comb begin
    base_a = is_shift_fn(bus.ex_op, bus.ex_funct) ? bus.ex_rfd2 : bus.ex_rfd1;
    if ((bus.ex_op == OP_RTYPE) && (bus.ex_funct == FN_SRLV)) base_b = bus.ex_rfd1;
    else if (ex_src_b_imm)                                   base_b = bus.ex_imm;
    else                                                     base_b = bus.ex_rfd2;

    unique case (bus.ex_sel_a)
      SEL_MEM: x = bus.mem_aluout;
      SEL_WB:  x = bus.wb_data;
      default: x = base_a;
    endcase
    unique case (bus.ex_sel_b)
      SEL_MEM: y = bus.mem_aluout;
      SEL_WB:  y = bus.wb_data;
      default: y = base_b;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [32:0] sum, diff;
  logic [63:0] prod;
  logic [31:0] quo, rem, sra_r;
  logic        add_of, sub_of;

  assign sum   = {1'b0, x} + {1'b0, y};
  assign diff  = {1'b0, x} - {1'b0, y};
  // Low 64 bits of the product of sign-extended operands == signed product.
  assign prod  = {{32{x[31]}}, x} * {{32{y[31]}}, y};
  assign quo   = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
  assign rem   = (y == 32'd0) ? x : x % y;
  assign sra_r = $signed(x) >>> y[4:0];

  assign add_of = (x[31] == y[31]) && (sum[31]  != x[31]);
  assign sub_of = (x[31] != y[31]) && (diff[31] != x[31]);

  always_comb begin
    bus.alu_r   = 32'd0;
    bus.alu_r2  = 32'd0;
    bus.alu_of  = 1'b0;
    bus.alu_uof = 1'b0;
    case (bus.ex_aluop)
      ALU_SLL:  bus.alu_r = x << y[4:0];
      ALU_SRA:  bus.alu_r = sra_r;
      ALU_SRL:  bus.alu_r = x >> y[4:0];
      ALU_MUL: begin
        bus.alu_r  = prod[31:0];
        bus.alu_r2 = prod[63:32];
      end
      ALU_DIVU: begin
        bus.alu_r  = quo;
        bus.alu_r2 = rem;
      end
      ALU_ADD: begin
        bus.alu_r   = sum[31:0];
        bus.alu_of  = add_of;
        bus.alu_uof = sum[32];
      end
      ALU_SUB: begin
        bus.alu_r   = diff[31:0];
        bus.alu_of  = sub_of;
        bus.alu_uof = diff[32];
      end
      ALU_AND:  bus.alu_r = x & y;
      ALU_OR:   bus.alu_r = x | y;
      ALU_XOR:  bus.alu_r = x ^ y;
      ALU_NOR:  bus.alu_r = ~(x | y);
      ALU_SLT:  bus.alu_r = {31'd0, $signed(x) < $signed(y)};
      ALU_SLTU: bus.alu_r = {31'd0, x < y};
      default:  bus.alu_r = 32'd0;
    endcase
  end

  assign bus.alu_eq = (x == y);

  // ---------------------------------------------------------------------
  // Optional stall-cycle counter
  // ---------------------------------------------------------------------
`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Block is purely combinational without the counter.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_ex_alu_hazard.sv
// Table-driven bench for ex_alu_hazard: ALU ops, operand muxing, forwarding
// selects and load-use stall, plus timed sequences for the stall counter.
module tb_ex_alu_hazard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_alu_hazard_if bus ();

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
  ex_alu_hazard dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  ex_alu_hazard dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt;
    logic [5:0]  ex_op, ex_funct;
    logic [4:0]  ex_rt, ex_rd;
    logic [5:0]  mem_op, mem_funct;
    logic [4:0]  mem_rt, mem_rd;
    logic [31:0] rfd1, rfd2, imm;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  aluop;
    logic [31:0] mem_aluout, wb_data;
    logic [31:0] e_r, e_r2;
    logic        e_of, e_uof, e_eq, e_stall;
    logic [1:0]  e_sa, e_sb, e_s1, e_s2;
  } vec_t;

  vec_t vecs[$];

  // Baseline: EX/ID hold "add $0,$0,$0", MEM holds a no-dest sll, operands 0.
  function automatic vec_t blank();
    vec_t v;
    v.id_op = 6'h00;  v.id_funct = 6'h20; v.id_rs = 5'd0; v.id_rt = 5'd0;
    v.ex_op = 6'h00;  v.ex_funct = 6'h20; v.ex_rt = 5'd0; v.ex_rd = 5'd0;
    v.mem_op = 6'h00; v.mem_funct = 6'h00; v.mem_rt = 5'd0; v.mem_rd = 5'd0;
    v.rfd1 = 32'd0; v.rfd2 = 32'd0; v.imm = 32'd0;
    v.sel_a = 2'b00; v.sel_b = 2'b00; v.aluop = 4'd5;
    v.mem_aluout = 32'd0; v.wb_data = 32'd0;
    v.e_r = 32'd0; v.e_r2 = 32'd0;
    v.e_of = 1'b0; v.e_uof = 1'b0; v.e_eq = 1'b1; v.e_stall = 1'b0;
    v.e_sa = 2'b00; v.e_sb = 2'b00; v.e_s1 = 2'b00; v.e_s2 = 2'b00;
    return v;
  endfunction

  // ALU-only vector: X=rfd1, Y=rfd2 through the plain add-style path.
  function automatic vec_t alu_v(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] r, input logic [31:0] r2,
                                 input logic of, input logic uof, input logic eq);
    vec_t v;
    v = blank();
    v.aluop = op; v.rfd1 = a; v.rfd2 = b;
    v.e_r = r; v.e_r2 = r2; v.e_of = of; v.e_uof = uof; v.e_eq = eq;
    return v;
  endfunction

  function automatic vec_t sel_v(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] d);
    vec_t v;
    v = blank();
    v.e_stall = s; v.e_sa = a; v.e_sb = b; v.e_s1 = c; v.e_s2 = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_op = v.id_op; bus.id_funct = v.id_funct; bus.id_rs = v.id_rs; bus.id_rt = v.id_rt;
    bus.ex_op = v.ex_op; bus.ex_funct = v.ex_funct; bus.ex_rt = v.ex_rt; bus.ex_rd = v.ex_rd;
    bus.mem_op = v.mem_op; bus.mem_funct = v.mem_funct;
    bus.mem_rt = v.mem_rt; bus.mem_rd = v.mem_rd;
    bus.ex_rfd1 = v.rfd1; bus.ex_rfd2 = v.rfd2; bus.ex_imm = v.imm;
    bus.ex_sel_a = v.sel_a; bus.ex_sel_b = v.sel_b; bus.ex_aluop = v.aluop;
    bus.mem_aluout = v.mem_aluout; bus.wb_data = v.wb_data;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d alu_r", i),   bus.alu_r, v.e_r);
    chk($sformatf("v%0d alu_r2", i),  bus.alu_r2, v.e_r2);
    chk($sformatf("v%0d alu_of", i),  32'(bus.alu_of), 32'(v.e_of));
    chk($sformatf("v%0d alu_uof", i), 32'(bus.alu_uof), 32'(v.e_uof));
    chk($sformatf("v%0d alu_eq", i),  32'(bus.alu_eq), 32'(v.e_eq));
    chk($sformatf("v%0d stall", i),   32'(bus.stall), 32'(v.e_stall));
    chk($sformatf("v%0d id_sel_a", i),    32'(bus.id_sel_a), 32'(v.e_sa));
    chk($sformatf("v%0d id_sel_b", i),    32'(bus.id_sel_b), 32'(v.e_sb));
    chk($sformatf("v%0d id_rfd1_sel", i), 32'(bus.id_rfd1_sel), 32'(v.e_s1));
    chk($sformatf("v%0d id_rfd2_sel", i), 32'(bus.id_rfd2_sel), 32'(v.e_s2));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(blank());

    // ---------------- ALU table ----------------
    vecs.push_back(blank());
    vecs.push_back(alu_v(4'd5, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd5, 32'hFFFFFFFF, 32'h1, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(alu_v(4'd6, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(alu_v(4'd6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd3, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd4, 32'd17, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd4, 32'd17, 32'd0, 32'hFFFFFFFF, 32'd17, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd0, 32'h1, 32'd31, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd1, 32'h80000000, 32'h24, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd2, 32'h80000000, 32'h24, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd7, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd8, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd9, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd10, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd11, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd12, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(alu_v(4'd13, 32'h1234, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));

    // ---------------- operand muxing ----------------
    v = alu_v(4'd8, 32'h1, 32'h0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    v.sel_a = 2'b01; v.mem_aluout = 32'h100; v.wb_data = 32'h55; vecs.push_back(v);
    v.sel_a = 2'b10; v.e_r = 32'h55; vecs.push_back(v);
    v.sel_a = 2'b11; v.e_r = 32'h1; vecs.push_back(v);
    v = alu_v(4'd8, 32'h0, 32'h3, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);
    v.sel_b = 2'b01; v.mem_aluout = 32'h30; vecs.push_back(v);
    v.sel_b = 2'b11; v.e_r = 32'h3; vecs.push_back(v);
    // srlv: A = rt value, B = rs value
    v = alu_v(4'd2, 32'h4, 32'h80, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    v.ex_funct = 6'h06; vecs.push_back(v);
    // addi: B = immediate
    v = alu_v(4'd5, 32'h0A, 32'h63, 32'h0F, 32'h0, 1'b0, 1'b0, 1'b0);
    v.ex_op = 6'h08; v.imm = 32'd5; vecs.push_back(v);
    // sll: A = rt value, B = immediate shamt
    v = alu_v(4'd0, 32'h99, 32'h3, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);
    v.ex_funct = 6'h00; v.imm = 32'd4; vecs.push_back(v);

    // ---------------- hazards / forwarding ----------------
    v = sel_v(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);            // lw rt=8 -> add rs=8
    v.ex_op = 6'h23; v.ex_rt = 5'd8; v.id_rs = 5'd8; v.id_rt = 5'd3; vecs.push_back(v);
    v = sel_v(1'b0, 2'b01, 2'b01, 2'b01, 2'b01);            // EX beats MEM
    v.ex_rd = 5'd9; v.mem_funct = 6'h20; v.mem_rd = 5'd9;
    v.id_rs = 5'd9; v.id_rt = 5'd9; vecs.push_back(v);
    v = sel_v(1'b0, 2'b10, 2'b01, 2'b10, 2'b01);            // MEM rd=9, EX rd=5
    v.ex_rd = 5'd5; v.mem_funct = 6'h20; v.mem_rd = 5'd9;
    v.id_rs = 5'd9; v.id_rt = 5'd5; vecs.push_back(v);
    v = sel_v(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // addi rt=0: no dest
    v.ex_op = 6'h08; v.ex_rt = 5'd0; v.ex_rd = 5'd7; v.id_rt = 5'd7; vecs.push_back(v);
    v = sel_v(1'b0, 2'b01, 2'b00, 2'b00, 2'b01);            // ID sll reads rt on A
    v.ex_op = 6'h08; v.ex_rt = 5'd6;
    v.id_funct = 6'h00; v.id_rs = 5'd7; v.id_rt = 5'd6; vecs.push_back(v);
    v = sel_v(1'b0, 2'b00, 2'b10, 2'b10, 2'b00);            // ID srlv, MEM lw rt=4
    v.mem_op = 6'h23; v.mem_rt = 5'd4;
    v.id_funct = 6'h06; v.id_rs = 5'd4; v.id_rt = 5'd5; vecs.push_back(v);
    v = sel_v(1'b0, 2'b01, 2'b00, 2'b01, 2'b01);            // EX jal -> $31, ID addi
    v.ex_op = 6'h03; v.id_op = 6'h08; v.id_rs = 5'd31; v.id_rt = 5'd31; vecs.push_back(v);
    v = sel_v(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);            // lbu rt=12 -> sw rt=12
    v.ex_op = 6'h24; v.ex_rt = 5'd12; v.id_op = 6'h2B; v.id_rs = 5'd1; v.id_rt = 5'd12;
    vecs.push_back(v);
    v = sel_v(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // lw rt=0 never stalls
    v.ex_op = 6'h23; v.ex_rt = 5'd0; vecs.push_back(v);
    v = sel_v(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);            // jr / syscall: no dest
    v.ex_funct = 6'h08; v.ex_rd = 5'd9; v.mem_funct = 6'h0C; v.mem_rd = 5'd9;
    v.id_rs = 5'd9; v.id_rt = 5'd9; vecs.push_back(v);

    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Combinational stall release: no clock edge between the two samples.
    @(negedge clk);
    v = blank();
    v.ex_op = 6'h23; v.ex_rt = 5'd8; v.id_rs = 5'd8;
    drive(v);
    #1 chk("seq stall_on", 32'(bus.stall), 32'd1);
    bus.id_rs = 5'd2;
    #1 chk("seq stall_off", 32'(bus.stall), 32'd0);

`ifdef STALL_CNT_EN
    @(negedge clk);
    drive(blank());
    rst = 1'b0;
    #1 chk("cnt reset", 32'(stall_cnt), 32'd0);
    rst = 1'b1;
    bus.ex_op = 6'h23; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    @(negedge clk);
    @(negedge clk);
    chk("cnt two stalls", 32'(stall_cnt), 32'd2);
    bus.id_rs = 5'd1;
    @(negedge clk);
    chk("cnt hold", 32'(stall_cnt), 32'd2);
    bus.id_rt = 5'd8;
    @(negedge clk);
    chk("cnt three", 32'(stall_cnt), 32'd3);
    #1 rst = 1'b0;
    #1 chk("cnt async clear", 32'(stall_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("cnt restart", 32'(stall_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
